multi_port_regfile: RTL and testbench
=====================================

MULTI_PORT_REGFILE -- requirements
Module: multi_port_regfile

Interface
REQ-001 The block SHALL have parameter XLEN, default 64, meaning register data width in bits.
REQ-002 The block SHALL have parameter NREG, default 32, meaning the number of architectural registers (power of two, at least 2), with index width AW = log2(NREG).
REQ-003 The block SHALL have parameter NRD, default 4, meaning the number of read ports.
REQ-004 The block SHALL have parameter NWR, default 2, meaning the number of write ports (1 to 4).
REQ-005 The block SHALL have parameter TAGW, default 2, meaning the commit-tag width, with 2^TAGW >= NWR.
REQ-006 The block SHALL have parameter BYPASS, default 1, meaning that same-cycle accepted write data is forwarded to reads when BYPASS is 1.
REQ-007 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-008 The block SHALL have port reset, input, 1 bit: asynchronous reset, active-high.
REQ-009 The block SHALL have port rd_en_i, input, NRD bits: per-read-port enable.
REQ-010 The block SHALL have port rd_addr_i, input, NRD*AW bits: per-read-port register index.
REQ-011 The block SHALL have port rd_data_o, output, NRD*XLEN bits: per-read-port data.
REQ-012 The block SHALL have port wr_valid_i, input, NWR bits: per-write-port request valid.
REQ-013 The block SHALL have port wr_addr_i, input, NWR*AW bits: per-write-port destination index.
REQ-014 The block SHALL have port wr_data_i, input, NWR*XLEN bits: per-write-port data.
REQ-015 The block SHALL have port wr_tag_i, input, NWR*TAGW bits: per-write-port program-order commit tag.
REQ-016 The block SHALL have port wr_ready_o, output, NWR bits: per-write-port accept indication.
REQ-017 The block SHALL have port commit_ptr_o, output, TAGW bits: the next expected commit tag.

Function
REQ-018 Register 0 SHALL always read as zero; writes to index 0 SHALL be accepted and discarded, and SHALL NOT be bypassed.
REQ-019 Reads SHALL be combinational: a read port SHALL return zero when its rd_en_i bit is 0, and Register[addr] otherwise.
REQ-020 The block SHALL hold an internal commit_ptr register (TAGW bits) and drive it on commit_ptr_o.
REQ-021 Write acceptance SHALL be strictly in tag order, evaluated each cycle for k = 0..NWR-1: the slot with tag commit_ptr+k (mod 2^TAGW) is accepted if and only if a valid port carries that tag and slots 0..k-1 were all accepted.
REQ-022 A port SHALL have wr_ready_o=1 if and only if it is valid and accepted; a valid port whose tag is outside the contiguous accepted run SHALL see wr_ready_o=0 and must hold its request.
REQ-023 wr_ready_o SHALL depend only on wr_valid_i, wr_tag_i and commit_ptr (no combinational path from wr_data_i).
REQ-024 If two valid ports carry the same tag, only the lower-index port SHALL be eligible and the higher-index port SHALL get ready=0 (protocol violation, deterministic handling).
REQ-025 On each rising clk edge, commit_ptr SHALL advance by the number of accepted writes, modulo 2^TAGW (wrap-around from 2^TAGW-1 to 0 is normal operation).
REQ-026 Accepted writes SHALL update the array on the same rising edge, so the data is visible in the array on the next cycle.
REQ-027 When accepted writes in the same cycle target the same index, the write with the later slot (younger in program order) SHALL win.
REQ-028 When BYPASS=1, a read whose enabled address matches an accepted same-cycle write SHALL return the youngest matching write data; when BYPASS=0, it SHALL return the old array value.
REQ-029 Invalid ports SHALL be ignored regardless of their tag, address or data values.
REQ-030 When no port is valid, or no valid port carries commit_ptr, nothing SHALL be accepted and commit_ptr SHALL hold.

Reset
REQ-031 While reset is high, commit_ptr SHALL be 0, all registers SHALL be 0, and wr_ready_o SHALL be 0.
REQ-032 While reset is high, rd_data_o SHALL be all zeros.
REQ-033 Assertion of reset mid-stream SHALL take effect immediately, with no clock required, and SHALL discard all pending requests.
REQ-034 After reset is released, the first accepted tag SHALL be 0.

Verification
REQ-035 The bench SHALL cover in-order dual write: ptr=0, port0 (tag0, x5=0xAA), port1 (tag1, x6=0xBB) -> both ready=1; ptr becomes 2 next cycle; x5 reads 0xAA and x6 reads 0xBB.
REQ-036 The bench SHALL cover an out-of-order hold: ptr=0, only port1 valid (tag1) -> ready=0 and ptr stays 0; next cycle port0 tag0 is added -> both ready=1 and ptr becomes 2.
REQ-037 The bench SHALL cover a same-address conflict: ptr=3, port0 (tag0, x7=1), port1 (tag3, x7=2) -> order is tag3 then tag0, so x7=1 and ptr wraps to 1.
REQ-038 The bench SHALL cover bypass: BYPASS=1, accepted write x9=0x1234 with read port 2 enabled on x9 in the same cycle -> reads 0x1234; with BYPASS=0 -> reads the old value.
REQ-039 The bench SHALL cover x0 and read enable: write x0=0xFF -> ready=1 and x0 still reads 0; a read with rd_en_i=0 on x5 -> reads 0.
REQ-040 The bench SHALL cover mid-operation reset: after writes, assert reset between clock edges -> all reads 0 and ptr=0 immediately; after release, a tag1 request is held until a tag0 request arrives.

Source files
------------

// File: rtl/multi_port_regfile.sv
// Multi-ported register file with in-order (tag-ordered) write commit and
// optional same-cycle write-to-read bypass. Register 0 is hardwired to zero.
module multi_port_regfile #(
    parameter  int XLEN   = 64,
    parameter  int NREG   = 32,
    parameter  int NRD    = 4,
    parameter  int NWR    = 2,
    parameter  int TAGW   = 2,
    parameter  int BYPASS = 1,
    localparam int AW     = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NRD-1:0]       rd_en_i,
    input  logic [NRD*AW-1:0]    rd_addr_i,
    output logic [NRD*XLEN-1:0]  rd_data_o,
    input  logic [NWR-1:0]       wr_valid_i,
    input  logic [NWR*AW-1:0]    wr_addr_i,
    input  logic [NWR*XLEN-1:0]  wr_data_i,
    input  logic [NWR*TAGW-1:0]  wr_tag_i,
    output logic [NWR-1:0]       wr_ready_o,
    output logic [TAGW-1:0]      commit_ptr_o
);

    logic [XLEN-1:0] regs [NREG];
    logic [TAGW-1:0] commit_ptr;

    // Per commit slot k (tag commit_ptr+k): one-hot port select, accept flag, payload
    logic [NWR-1:0]  slot_sel  [NWR];
    logic [NWR-1:0]  slot_acc;
    logic [AW-1:0]   slot_addr [NWR];
    logic [XLEN-1:0] slot_data [NWR];
    logic [TAGW-1:0] n_acc;

    // Acceptance uses only valid/tag/commit_ptr, so ready never depends on write data.
    always_comb begin : accept_logic
        logic            run;
        logic [TAGW-1:0] want;
        logic [NWR-1:0]  match;
        run        = ~reset;
        want       = '0;
        match      = '0;
        wr_ready_o = '0;
        slot_acc   = '0;
        n_acc      = '0;
        for (int k = 0; k < NWR; k++) begin
            want = commit_ptr + TAGW'(k);
            for (int p = 0; p < NWR; p++)
                match[p] = wr_valid_i[p] && (wr_tag_i[p*TAGW +: TAGW] == want);
            // Lowest set bit: a duplicated tag is only eligible on the lower-index port.
            slot_sel[k] = match & (~match + NWR'(1));
            run = run && (match != '0);
            if (run) begin
                slot_acc[k] = 1'b1;
                wr_ready_o  = wr_ready_o | slot_sel[k];
                n_acc       = n_acc + TAGW'(1);
            end
        end
    end

    always_comb begin : slot_payload
        for (int k = 0; k < NWR; k++) begin
            slot_addr[k] = '0;
            slot_data[k] = '0;
            for (int p = 0; p < NWR; p++) begin
                if (slot_sel[k][p]) begin
                    slot_addr[k] = wr_addr_i[p*AW +: AW];
                    slot_data[k] = wr_data_i[p*XLEN +: XLEN];
                end
            end
        end
    end

    always_comb begin : read_ports
        logic [AW-1:0]   a;
        logic [XLEN-1:0] v;
        a         = '0;
        v         = '0;
        rd_data_o = '0;
        for (int r = 0; r < NRD; r++) begin
            a = rd_addr_i[r*AW +: AW];
            v = regs[a];
            // Ascending slot order leaves the youngest matching write on the port.
            if (BYPASS != 0) begin
                for (int k = 0; k < NWR; k++)
                    if (slot_acc[k] && (slot_addr[k] == a) && (a != '0))
                        v = slot_data[k];
            end
            if (!rd_en_i[r] || reset)
                v = '0;
            rd_data_o[r*XLEN +: XLEN] = v;
        end
    end

    // NOTE: the array is cleared by reset because reset must make every register read zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            commit_ptr <= '0;
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
        end else begin
            commit_ptr <= commit_ptr + n_acc;
            // NOTE: non-blocking writes in slot order, so a later slot to the same index wins.
            for (int k = 0; k < NWR; k++)
                if (slot_acc[k] && (slot_addr[k] != '0))
                    regs[slot_addr[k]] <= slot_data[k];
        end
    end

    assign commit_ptr_o = commit_ptr;

endmodule

// File: tb/tb_multi_port_regfile.sv
// Self-checking bench for multi_port_regfile: acceptance vector table, directed
// corner sequences, and randomized traffic against a tag-ordered reference model.
module tb_multi_port_regfile;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int NRD  = 4;
    localparam int NWR  = 2;
    localparam int TAGW = 2;
    localparam int AW   = 5;
    localparam int NTAG = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic [NRD-1:0]      rd_en;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NWR-1:0]      wr_valid;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic [NWR*TAGW-1:0] wr_tag;
    logic [NRD*XLEN-1:0] rd_data, rd_data_nb;
    logic [NWR-1:0]      ready, ready_nb;
    logic [TAGW-1:0]     ptr, ptr_nb;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multi_port_regfile #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .TAGW(TAGW), .BYPASS(1)) dut (
        .clk(clk), .reset(reset), .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
        .wr_valid_i(wr_valid), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_tag_i(wr_tag),
        .wr_ready_o(ready), .commit_ptr_o(ptr)
    );

    multi_port_regfile #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .TAGW(TAGW), .BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data_nb),
        .wr_valid_i(wr_valid), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_tag_i(wr_tag),
        .wr_ready_o(ready_nb), .commit_ptr_o(ptr_nb)
    );

    // Reference model: architectural registers, next expected tag, and this cycle's accepted ports.
    logic [63:0]    mregs [NREG];
    int             mptr;
    int             acc_port [NWR];
    int             n_acc;
    logic [NWR-1:0] m_ready;

    typedef struct {
        logic [1:0] v;
        int         t0;
        int         t1;
        logic [1:0] exp_rdy;
        int         exp_ptr;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        rd_en = '0; rd_addr = '0; wr_valid = '0; wr_addr = '0; wr_data = '0; wr_tag = '0;
    endtask

    task automatic set_wr(input int p, input logic v, input int a, input logic [63:0] d, input int t);
        wr_valid[p]              = v;
        wr_addr[p*AW +: AW]      = AW'(a);
        wr_data[p*XLEN +: XLEN]  = d;
        wr_tag[p*TAGW +: TAGW]   = TAGW'(t);
    endtask

    task automatic set_rd(input int r, input logic en, input int a);
        rd_en[r]            = en;
        rd_addr[r*AW +: AW] = AW'(a);
    endtask

    function automatic logic [63:0] rdv(input int r);
        return rd_data[r*XLEN +: XLEN];
    endfunction

    function automatic logic [63:0] rdv_nb(input int r);
        return rd_data_nb[r*XLEN +: XLEN];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) mregs[i] = '0;
        mptr = 0;
    endtask

    // Walk tags upward from mptr; each needs a fresh valid port carrying it, else stop.
    task automatic model_accept();
        logic [NWR-1:0] taken;
        int cur;
        int found;
        taken = '0;
        cur   = mptr;
        n_acc = 0;
        for (int s = 0; s < NWR; s++) begin
            found = -1;
            for (int p = 0; p < NWR; p++)
                if (found < 0 && !taken[p] && wr_valid[p] && int'(wr_tag[p*TAGW +: TAGW]) == cur)
                    found = p;
            if (found < 0) break;
            taken[found]    = 1'b1;
            acc_port[n_acc] = found;
            n_acc++;
            cur = (cur + 1) % NTAG;
        end
        m_ready = taken;
    endtask

    task automatic model_read(input int r, input logic byp, output logic [63:0] v);
        int a;
        int p;
        a = int'(rd_addr[r*AW +: AW]);
        v = '0;
        if (rd_en[r]) begin
            v = mregs[a];
            if (byp) begin
                for (int i = 0; i < n_acc; i++) begin
                    p = acc_port[i];
                    if (int'(wr_addr[p*AW +: AW]) == a && a != 0) v = wr_data[p*XLEN +: XLEN];
                end
            end
        end
    endtask

    task automatic check_model();
        logic [63:0] e;
        model_accept();
        check("rand_ready", 64'(ready), 64'(m_ready));
        check("rand_ptr", 64'(ptr), 64'(mptr));
        for (int r = 0; r < NRD; r++) begin
            model_read(r, 1'b1, e);
            check($sformatf("rand_rd%0d", r), rdv(r), e);
            model_read(r, 1'b0, e);
            check($sformatf("rand_rd%0d_nobypass", r), rdv_nb(r), e);
        end
    endtask

    // One rising edge; the model commits the same inputs the DUT sees, then 1ns of hold.
    task automatic step();
        int p;
        int a;
        @(posedge clk);
        model_accept();
        for (int i = 0; i < n_acc; i++) begin
            p = acc_port[i];
            a = int'(wr_addr[p*AW +: AW]);
            if (a != 0) mregs[a] = wr_data[p*XLEN +: XLEN];
        end
        mptr = (mptr + n_acc) % NTAG;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, with a valid tag-0 request and an enabled read present.
        reset = 1'b1;
        clear_inputs();
        model_reset();
        set_wr(0, 1'b1, 5, 64'hAA, 0);
        set_rd(0, 1'b1, 5);
        #3;
        check("reset_ready", 64'(ready), 64'h0);
        check("reset_ptr", 64'(ptr), 64'h0);
        check("reset_rd0", rdv(0), 64'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        clear_inputs();

        // Acceptance table, applied back to back starting from ptr=0.
        tbl[0] = '{2'b00, 0, 0, 2'b00, 0};
        tbl[1] = '{2'b10, 0, 1, 2'b00, 0};
        tbl[2] = '{2'b01, 0, 0, 2'b01, 1};
        tbl[3] = '{2'b11, 2, 1, 2'b11, 3};
        tbl[4] = '{2'b11, 3, 3, 2'b01, 0};
        tbl[5] = '{2'b11, 1, 1, 2'b00, 0};
        tbl[6] = '{2'b10, 0, 0, 2'b10, 1};
        tbl[7] = '{2'b11, 1, 2, 2'b11, 3};
        tbl[8] = '{2'b11, 0, 3, 2'b11, 1};
        tbl[9] = '{2'b01, 2, 0, 2'b00, 1};
        for (int i = 0; i < 10; i++) begin
            set_wr(0, tbl[i].v[0], 10, 64'h100 + 64'(i), tbl[i].t0);
            set_wr(1, tbl[i].v[1], 11, 64'h200 + 64'(i), tbl[i].t1);
            #4;
            check($sformatf("tbl%0d_ready", i), 64'(ready), 64'(tbl[i].exp_rdy));
            step();
            check($sformatf("tbl%0d_ptr", i), 64'(ptr), 64'(tbl[i].exp_ptr));
        end

        // In-order dual write.
        do_reset();
        set_wr(0, 1'b1, 5, 64'hAA, 0);
        set_wr(1, 1'b1, 6, 64'hBB, 1);
        #4;
        check("dual_ready", 64'(ready), 64'h3);
        step();
        clear_inputs();
        set_rd(0, 1'b1, 5);
        set_rd(1, 1'b1, 6);
        #4;
        check("dual_ptr", 64'(ptr), 64'h2);
        check("dual_x5", rdv(0), 64'hAA);
        check("dual_x6", rdv(1), 64'hBB);

        // Out-of-order request held until the older tag shows up.
        do_reset();
        set_wr(1, 1'b1, 12, 64'h36, 1);
        #4;
        check("ooo_hold_ready", 64'(ready), 64'h0);
        step();
        check("ooo_hold_ptr", 64'(ptr), 64'h0);
        set_wr(0, 1'b1, 13, 64'h35, 0);
        #4;
        check("ooo_both_ready", 64'(ready), 64'h3);
        step();
        check("ooo_ptr", 64'(ptr), 64'h2);

        // Same-address conflict across the tag wrap: tag3 is older than tag0.
        do_reset();
        set_wr(0, 1'b1, 20, 64'h1, 0);
        set_wr(1, 1'b1, 21, 64'h2, 1);
        step();
        clear_inputs();
        set_wr(0, 1'b1, 22, 64'h3, 2);
        step();
        check("conf_ptr3", 64'(ptr), 64'h3);
        clear_inputs();
        set_wr(0, 1'b1, 7, 64'h1, 0);
        set_wr(1, 1'b1, 7, 64'h2, 3);
        #4;
        check("conf_ready", 64'(ready), 64'h3);
        step();
        check("conf_ptr_wrap", 64'(ptr), 64'h1);
        clear_inputs();
        set_rd(0, 1'b1, 7);
        #4;
        check("conf_x7", rdv(0), 64'h1);
        check("conf_x7_nobypass", rdv_nb(0), 64'h1);

        // Bypass versus no-bypass on read port 2.
        do_reset();
        set_wr(0, 1'b1, 9, 64'h5555, 0);
        step();
        clear_inputs();
        set_wr(0, 1'b1, 9, 64'h1234, 1);
        set_rd(2, 1'b1, 9);
        #4;
        check("byp_on", rdv(2), 64'h1234);
        check("byp_off", rdv_nb(2), 64'h5555);
        step();
        clear_inputs();
        set_rd(2, 1'b1, 9);
        #4;
        check("byp_off_next", rdv_nb(2), 64'h1234);

        // x0 writes are accepted but discarded; disabled reads return zero.
        do_reset();
        set_wr(0, 1'b1, 5, 64'h55, 0);
        step();
        clear_inputs();
        set_wr(0, 1'b1, 0, 64'hFF, 1);
        set_rd(0, 1'b1, 0);
        set_rd(1, 1'b0, 5);
        set_rd(3, 1'b1, 5);
        #4;
        check("x0_ready", 64'(ready), 64'h1);
        check("x0_no_bypass", rdv(0), 64'h0);
        check("rd_disabled", rdv(1), 64'h0);
        check("rd_enabled_x5", rdv(3), 64'h55);
        step();
        clear_inputs();
        set_rd(0, 1'b1, 0);
        #4;
        check("x0_after", rdv(0), 64'h0);
        check("x0_ptr", 64'(ptr), 64'h2);

        // Mid-cycle reset clears everything without a clock edge.
        do_reset();
        set_wr(0, 1'b1, 5, 64'hAA, 0);
        set_wr(1, 1'b1, 6, 64'hBB, 1);
        step();
        clear_inputs();
        set_rd(0, 1'b1, 5);
        set_rd(1, 1'b1, 6);
        set_wr(0, 1'b1, 8, 64'h77, 2);
        #1;
        check("mid_pre_x5", rdv(0), 64'hAA);
        reset = 1'b1;
        #1;
        check("mid_x5", rdv(0), 64'h0);
        check("mid_x6", rdv(1), 64'h0);
        check("mid_ptr", 64'(ptr), 64'h0);
        check("mid_ready", 64'(ready), 64'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        clear_inputs();
        set_wr(1, 1'b1, 6, 64'hCC, 1);
        #4;
        check("post_hold_ready", 64'(ready), 64'h0);
        step();
        check("post_hold_ptr", 64'(ptr), 64'h0);
        set_wr(0, 1'b1, 5, 64'hDD, 0);
        #4;
        check("post_both_ready", 64'(ready), 64'h3);
        step();
        clear_inputs();
        set_rd(0, 1'b1, 5);
        set_rd(1, 1'b1, 6);
        #4;
        check("post_ptr", 64'(ptr), 64'h2);
        check("post_x5", rdv(0), 64'hDD);
        check("post_x6", rdv(1), 64'hCC);

        // Randomized traffic on a narrow address range to provoke conflicts.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < NWR; p++)
                set_wr(p, 1'($urandom), int'($urandom_range(0, 7)), {$urandom, $urandom},
                       int'($urandom_range(0, NTAG - 1)));
            for (int r = 0; r < NRD; r++)
                set_rd(r, 1'($urandom), int'($urandom_range(0, 7)));
            #4;
            check_model();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
